// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among
// NUM_REQ write-domain requesters, throttled on full/almost_full.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          wr_clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic                          full,
   input  logic                          almost_full,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          wr_enb,
   output logic [DATA_WIDTH-1:0]         wr_data,
   output logic [$clog2(NUM_REQ)-1:0]    owner,
   output logic                          busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] rr_ptr, pick, owner_inc;
   logic [CW-1:0] burst_cnt;
   logic          ok, accept, exit_b;
   int            idx;

   // the almost_full term accounts for the registered write already in flight
   assign ok        = !full && !(almost_full && wr_enb);
   assign busy      = (state == BURST);
   assign owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

   always_comb begin
      pick = rr_ptr;
      idx  = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[IW'(idx)]) pick = IW'(idx);
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      exit_b    = 1'b0;
      gnt       = '0;
      unique case (state)
         IDLE: begin
            if (|req) state_nxt = BURST;
         end
         BURST: begin
            accept = req[owner] && ok;
            if (accept) gnt[owner] = 1'b1;
            exit_b = !req[owner] ||
                     (accept && burst_cnt == CW'(MAX_BURST - 1));
            if (exit_b) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
         wr_enb    <= 1'b0;
         wr_data   <= '0;
      end else begin
         wr_enb <= accept;
         if (accept) begin
            wr_data   <= req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
            burst_cnt <= burst_cnt + 1'b1;
         end
         if (state == IDLE && |req) begin
            owner     <= pick;
            burst_cnt <= '0;
         end
         if (exit_b) rr_ptr <= owner_inc;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, round robin, throttling,
// requester withdrawal and asynchronous reset.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic          wr_clk = 1'b0;
   logic          rst = 1'b1;
   logic [NR-1:0] req = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic          full = 1'b0;
   logic          almost_full = 1'b0;
   logic [NR-1:0] gnt;
   logic          wr_enb;
   logic [DW-1:0] wr_data;
   logic [1:0]    owner;
   logic          busy;

   int checks = 0;
   int errors = 0;

   fifo_wr_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)
   ) dut (
      .wr_clk(wr_clk), .rst(rst), .req(req), .req_data(req_data),
      .full(full), .almost_full(almost_full), .gnt(gnt),
      .wr_enb(wr_enb), .wr_data(wr_data), .owner(owner), .busy(busy)
   );

   always #5 wr_clk = ~wr_clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [NR-1:0] r, input logic f,
                       input logic af);
      @(negedge wr_clk);
      req = r;
      full = f;
      almost_full = af;
      #1;
   endtask

   task automatic do_reset();
      @(negedge wr_clk);
      rst = 1'b1;
      req = '0;
      full = 1'b0;
      almost_full = 1'b0;
      req_data = '0;
      @(negedge wr_clk);
      rst = 1'b0;
   endtask

   int g1 [10] = '{0, 2, 2, 2, 2, 0, 2, 2, 2, 2};
   int e1 [10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1};
   int g3 [9]  = '{0, 4, 4, 0, 0, 0, 4, 4, 0};
   int e3 [9]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1};
   int f3 [9]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
   int a3 [9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
   int g4 [7]  = '{0, 1, 0, 1, 0, 0, 0};
   int e4 [7]  = '{0, 0, 1, 0, 1, 0, 0};
   int a4 [7]  = '{0, 0, 1, 1, 1, 1, 1};
   int f4 [7]  = '{0, 0, 0, 0, 0, 1, 1};
   int r5 [6]  = '{2, 2, 2, 9, 9, 9};
   int g5 [6]  = '{0, 2, 2, 0, 0, 8};
   int b5 [6]  = '{0, 1, 1, 1, 0, 1};

   initial begin
      int cnt [NR];
      int expw [$];
      int gotw [$];
      int nw;
      int eg;

      // reset state
      do_reset();
      #1;
      check("rst gnt", gnt, 0);
      check("rst wr_enb", wr_enb, 0);
      check("rst wr_data", wr_data, 0);
      check("rst owner", owner, 0);
      check("rst busy", busy, 0);

      // single continuous requester
      req_data = 32'h0000_A500;
      for (int i = 0; i < 10; i++) begin
         step(4'b0010, 1'b0, 1'b0);
         check($sformatf("t1 gnt c%0d", i), gnt, g1[i]);
         check($sformatf("t1 wr_enb c%0d", i), wr_enb, e1[i]);
         if (e1[i] != 0) check($sformatf("t1 data c%0d", i), wr_data, 8'hA5);
         if (i > 0) check($sformatf("t1 owner c%0d", i), owner, 1);
      end

      // all requesting: round robin, 4 words each
      do_reset();
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      for (int k = 0; k < 26; k++) begin
         @(negedge wr_clk);
         for (int i = 0; i < NR; i++)
            req_data[i*DW +: DW] = DW'(i*16 + cnt[i]);
         req = 4'b1111;
         #1;
         eg = (k % 5 == 0) ? 0 : (1 << ((k / 5) % 4));
         check($sformatf("t2 gnt c%0d", k), gnt, eg);
         if (wr_enb) gotw.push_back(int'(wr_data));
         for (int i = 0; i < NR; i++) if (gnt[i]) cnt[i]++;
      end
      for (int b = 0; b < 5; b++)
         for (int w = 0; w < MB; w++)
            expw.push_back((b % 4) * 16 + (b / 4) * 4 + w);
      check("t2 nwords", gotw.size(), 20);
      for (int i = 0; i < 20 && i < gotw.size(); i++)
         check($sformatf("t2 word%0d", i), gotw[i], expw[i]);

      // stall on almost_full then full mid-burst
      do_reset();
      req_data = 32'h00C3_0000;
      nw = 0;
      for (int i = 0; i < 9; i++) begin
         step((i == 8) ? 4'b0000 : 4'b0100, f3[i] != 0, a3[i] != 0);
         check($sformatf("t3 gnt c%0d", i), gnt, g3[i]);
         check($sformatf("t3 wr_enb c%0d", i), wr_enb, e3[i]);
         if (wr_enb) begin
            nw++;
            check($sformatf("t3 data c%0d", i), wr_data, 8'hC3);
         end
         if (i == 3 || i == 5)
            check($sformatf("t3 cnt c%0d", i), dut.burst_cnt, 2);
      end
      check("t3 nwords", nw, 4);

      // almost_full against the in-flight write
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(4'b0001, f4[i] != 0, a4[i] != 0);
         check($sformatf("t4 gnt c%0d", i), gnt, g4[i]);
         check($sformatf("t4 wr_enb c%0d", i), wr_enb, e4[i]);
      end
      check("t4 cnt", dut.burst_cnt, 2);

      // owner withdraws, pointer moves past it
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(NR'(r5[i]), 1'b0, 1'b0);
         check($sformatf("t5 gnt c%0d", i), gnt, g5[i]);
         check($sformatf("t5 busy c%0d", i), busy, b5[i]);
         if (i == 4) begin
            check("t5 rr_ptr", dut.rr_ptr, 2);
            check("t5 owner hold", owner, 1);
         end
         if (i == 5) check("t5 owner", owner, 3);
      end

      // asynchronous reset mid-burst
      do_reset();
      req_data = 32'h0000_5A00;
      for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 1'b0);
      check("t6 pre wr_enb", wr_enb, 1);
      check("t6 pre busy", busy, 1);
      #1;
      rst = 1'b1;
      req = '0;
      #1;
      check("t6 wr_enb", wr_enb, 0);
      check("t6 gnt", gnt, 0);
      check("t6 busy", busy, 0);
      check("t6 owner", owner, 0);
      @(negedge wr_clk);
      rst = 1'b0;
      step(4'b1001, 1'b0, 1'b0);
      check("t6 idle gnt", gnt, 0);
      step(4'b1001, 1'b0, 1'b0);
      check("t6 gnt0", gnt, 1);
      check("t6 owner0", owner, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
